// File: rtl/seg_capture.sv
// Captures a multiplexed 7-segment HH:MM:SS display into a BCD frame.
// Each digit must be seen stable for STABLE_CNT qualified samples before it is accepted.
module seg_capture #(
  parameter int STABLE_CNT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic [5:0]  dig_en,
  input  logic        sample_en,
  output logic [23:0] frame_bcd,
  output logic        frame_valid,
  output logic        pattern_err
);

  localparam logic [3:0] STABLE = 4'(STABLE_CNT);

  logic [12:0] samp_q, samp_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  seen_q, seen_d;
  logic [23:0] shadow_q, shadow_d;
  logic [23:0] frame_q, frame_d;
  logic        fv_q, fv_d;
  logic        pe_q, pe_d;

  logic        onehot;
  logic        commit;
  logic [2:0]  idx;
  logic        dec_ok;
  logic [3:0]  dec_val;
  logic        in_range;

  // Active-low segment patterns, {g,f,e,d,c,b,a}
  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'd0;
    unique case (seg_in)
      7'b1000000: dec_val = 4'd0;
      7'b1111001: dec_val = 4'd1;
      7'b0100100: dec_val = 4'd2;
      7'b0110000: dec_val = 4'd3;
      7'b0011001: dec_val = 4'd4;
      7'b0010010: dec_val = 4'd5;
      7'b0000010: dec_val = 4'd6;
      7'b1111000: dec_val = 4'd7;
      7'b0000000: dec_val = 4'd8;
      7'b0010000: dec_val = 4'd9;
      default:    dec_ok  = 1'b0;
    endcase
  end

  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (dig_en[i]) idx = 3'(i);
    end
  end

  assign onehot = (dig_en != 6'd0) && ((dig_en & (dig_en - 6'd1)) == 6'd0);

  // Tens digits of seconds/minutes stop at 5, tens of hours at 2
  always_comb begin
    in_range = 1'b1;
    if ((idx == 3'd1 || idx == 3'd3) && dec_val > 4'd5) in_range = 1'b0;
    if (idx == 3'd5 && dec_val > 4'd2) in_range = 1'b0;
  end

  always_comb begin
    samp_d   = samp_q;
    cnt_d    = cnt_q;
    seen_d   = seen_q;
    shadow_d = shadow_q;
    frame_d  = frame_q;
    fv_d     = 1'b0;
    pe_d     = 1'b0;
    commit   = 1'b0;

    if (sample_en) begin
      if (!onehot) begin
        cnt_d = 4'd0;
      end else if ({dig_en, seg_in} == samp_q) begin
        if (cnt_q < STABLE) begin
          cnt_d  = cnt_q + 4'd1;
          commit = (cnt_q + 4'd1 == STABLE);
        end
      end else begin
        samp_d = {dig_en, seg_in};
        cnt_d  = 4'd1;
        commit = (STABLE == 4'd1);
      end
    end

    if (commit) begin
      if (!dec_ok || !in_range) begin
        pe_d   = 1'b1;
        seen_d = 6'd0;
      end else begin
        shadow_d[{idx, 2'b00} +: 4] = dec_val;
        seen_d[idx] = 1'b1;
        if (seen_d == 6'b111111) begin
          frame_d = shadow_d;
          fv_d    = 1'b1;
          seen_d  = 6'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q   <= '0;
      cnt_q    <= '0;
      seen_q   <= '0;
      shadow_q <= '0;
      frame_q  <= '0;
      fv_q     <= 1'b0;
      pe_q     <= 1'b0;
    end else begin
      samp_q   <= samp_d;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      fv_q     <= fv_d;
      pe_q     <= pe_d;
    end
  end

  assign frame_bcd   = frame_q;
  assign frame_valid = fv_q;
  assign pattern_err = pe_q;

endmodule

// File: tb/tb_seg_capture.sv
// Randomized and directed bench for seg_capture; a run-length reference model
// queues expected pulses and a negedge monitor checks whatever the DUT emits.
module tb_seg_capture;

  localparam int ST = 3;
  localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                      7'b0000000, 7'b0010000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_in = 7'h7f;
  logic [5:0]  dig_en = 6'd0;
  logic        sample_en = 1'b0;
  logic [23:0] frame_bcd;
  logic        frame_valid;
  logic        pattern_err;

  seg_capture #(.STABLE_CNT(ST)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .dig_en(dig_en), .sample_en(sample_en),
    .frame_bcd(frame_bcd), .frame_valid(frame_valid), .pattern_err(pattern_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [23:0] frame;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_err = 0;
  bit          in_reset = 1'b1;

  logic [12:0] m_last;
  int          m_run;
  int          m_shadow[6];
  bit          m_seen[6];
  logic [23:0] m_frame;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int seg_value(input logic [6:0] s);
    for (int v = 0; v < 10; v++) if (SEG[v] == s) return v;
    return -1;
  endfunction

  task automatic model_reset();
    m_last  = '0;
    m_run   = 0;
    m_frame = '0;
    for (int i = 0; i < 6; i++) begin
      m_shadow[i] = 0;
      m_seen[i]   = 1'b0;
    end
  endtask

  task automatic model_commit(input logic [5:0] d, input logic [6:0] s);
    int   pos;
    int   v;
    bit   bad;
    bit   all;
    exp_t e;
    pos = 0;
    for (int i = 0; i < 6; i++) if (d[i]) pos = i;
    v   = seg_value(s);
    bad = (v < 0) || ((pos == 1 || pos == 3) && v > 5) || (pos == 5 && v > 2);
    if (bad) begin
      for (int i = 0; i < 6; i++) m_seen[i] = 1'b0;
      e.is_err = 1'b1;
      e.frame  = m_frame;
      exp_q.push_back(e);
    end else begin
      m_shadow[pos] = v;
      m_seen[pos]   = 1'b1;
      all = 1'b1;
      for (int i = 0; i < 6; i++) all &= m_seen[i];
      if (all) begin
        for (int i = 0; i < 6; i++) begin
          m_frame[4*i +: 4] = 4'(m_shadow[i]);
          m_seen[i] = 1'b0;
        end
        e.is_err = 1'b0;
        e.frame  = m_frame;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic model_step(input logic [5:0] d, input logic [6:0] s, input logic en);
    if (!en) return;
    if ($countones(d) != 1) begin
      m_run = 0;
      return;
    end
    if ({d, s} == m_last) m_run++;
    else begin
      m_last = {d, s};
      m_run  = 1;
    end
    if (m_run == ST) model_commit(d, s);
  endtask

  task automatic cyc(input logic [5:0] d, input logic [6:0] s, input logic en);
    dig_en    = d;
    seg_in    = s;
    sample_en = en;
    @(posedge clk);
    #1;
    model_step(d, s, en);
  endtask

  task automatic hold(input int pos, input int val, input int reps);
    for (int k = 0; k < reps; k++) cyc(6'(1 << pos), SEG[val], 1'b1);
  endtask

  task automatic do_reset();
    in_reset = 1'b1;
    rst      = 1'b1;
    for (int k = 0; k < 3; k++) begin
      dig_en    = 6'b000001;
      seg_in    = SEG[k];
      sample_en = 1'b1;
      @(posedge clk);
      #1;
    end
    model_reset();
    chk("reset_frame", 32'(frame_bcd), 32'h0);
    chk("reset_valid", 32'(frame_valid), 32'h0);
    chk("reset_err", 32'(pattern_err), 32'h0);
    rst       = 1'b0;
    sample_en = 1'b0;
    dig_en    = 6'd0;
    in_reset  = 1'b0;
  endtask

  // Monitor: every pulse must match the head of the expected queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!in_reset) begin
        if (frame_valid && pattern_err) begin
          n_checks++;
          n_err++;
          $display("FAIL both_pulses actual=11 required=not both");
        end
        if (frame_valid || pattern_err) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_pulse actual=valid%0b/err%0b required=none", frame_valid, pattern_err);
          end else begin
            e = exp_q.pop_front();
            chk("pulse_kind_err", 32'(pattern_err), 32'(e.is_err));
            chk("pulse_frame", 32'(frame_bcd), 32'(e.frame));
          end
        end else begin
          chk("frame_stable", 32'(frame_bcd), 32'(m_frame));
        end
      end
    end
  end

  initial begin
    int vals[6];
    int pos, val, reps;
    model_reset();
    do_reset();

    // 12:34:56
    vals = '{6, 5, 4, 3, 2, 1};
    for (int i = 0; i < 6; i++) hold(i, vals[i], 3);
    cyc(6'd0, 7'h7f, 1'b0);
    chk("frame_123456", 32'(frame_bcd), 32'h123456);

    // long dwell on digit 2
    for (int i = 0; i < 6; i++) hold(i, (i == 2) ? 7 : vals[i], (i == 2) ? 10 : 3);
    cyc(6'd0, 7'h7f, 1'b0);
    chk("frame_dwell", 32'(frame_bcd), 32'h123756);

    // out-of-range '8' on seconds tens, then a clean scan
    hold(0, 9, 3);
    hold(1, 8, 3);
    cyc(6'd0, 7'h7f, 1'b0);
    chk("frame_after_err", 32'(frame_bcd), 32'h123756);
    vals = '{9, 4, 8, 5, 3, 2};
    for (int i = 0; i < 6; i++) hold(i, vals[i], 3);
    cyc(6'd0, 7'h7f, 1'b0);
    chk("frame_rescan", 32'(frame_bcd), 32'h235849);

    // flicker, then blanking-separated partial dwells
    for (int k = 0; k < 10; k++) hold(0, (k % 2) ? 1 : 7, 1);
    hold(0, 4, 2); cyc(6'd0, 7'h7f, 1'b1);
    hold(0, 4, 2); cyc(6'd0, 7'h7f, 1'b1);
    hold(0, 4, 3);
    for (int i = 1; i < 6; i++) hold(i, 1, 3);
    cyc(6'd0, 7'h7f, 1'b0);
    chk("frame_blank", 32'(frame_bcd), 32'h111114);

    // reset mid-frame
    for (int i = 0; i < 4; i++) hold(i, 2, 3);
    do_reset();
    hold(4, 0, 3);
    hold(5, 1, 3);
    cyc(6'd0, 7'h7f, 1'b0);
    chk("frame_post_reset_partial", 32'(frame_bcd), 32'h0);
    for (int i = 0; i < 4; i++) hold(i, 3, 3);
    cyc(6'd0, 7'h7f, 1'b0);
    chk("frame_post_reset_full", 32'(frame_bcd), 32'h103333);

    // randomized scanning with gaps, blanking, bad patterns and multi-hot strobes
    for (int n = 0; n < 600; n++) begin
      pos  = $urandom_range(0, 5);
      val  = $urandom_range(0, 9);
      if (pos == 5 && $urandom_range(0, 3) != 0) val = $urandom_range(0, 2);
      if ((pos == 1 || pos == 3) && $urandom_range(0, 3) != 0) val = $urandom_range(0, 5);
      reps = $urandom_range(1, 5);
      for (int k = 0; k < reps; k++) begin
        if ($urandom_range(0, 19) == 0)
          cyc(6'(1 << pos), 7'($urandom), 1'b1);
        else
          cyc(6'(1 << pos), SEG[val], ($urandom_range(0, 4) != 0));
      end
      case ($urandom_range(0, 9))
        0: cyc(6'd0, 7'($urandom), 1'b1);
        1: cyc(6'b100001, SEG[val], 1'b1);
        default: ;
      endcase
    end

    repeat (3) cyc(6'd0, 7'h7f, 1'b0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
